// File: rtl/systolic_weight_sched_pkg.sv
// rtl/systolic_weight_sched_pkg.sv - shared array constants, state encoding and widths for the weight scheduler
package systolic_weight_sched_pkg;

    // Array geometry defaults shared with the rest of the systolic datapath
    localparam int WS_PE_ROW   = 8;
    localparam int WS_PE_COL   = 8;
    localparam int WS_ADDR_W   = 15;
    localparam int WS_ROW_ID_W = 3;

    // Scheduler state encoding
    localparam int WS_STATE_W = 3;

    localparam logic [WS_STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [WS_STATE_W-1:0] ST_READ  = 3'd1;
    localparam logic [WS_STATE_W-1:0] ST_DRAIN = 3'd2;
    localparam logic [WS_STATE_W-1:0] ST_PAD   = 3'd3;
    localparam logic [WS_STATE_W-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/systolic_wsched_pipe.sv
// rtl/systolic_wsched_pipe.sv - one-stage alignment of weight latch enables to the SRAM read latency
//
// Ports:
//   CLK, RSTb      clock, asynchronous active-low reset
//   i_flush        drop the in-flight row (abort)
//   i_valid        a row was issued this cycle (read or zero pad)
//   i_sel          1 = SRAM data, 0 = zero weights for the issued row
//   i_row_id       row issued this cycle
//   i_mask         latched column mask
//   o_en_w         per-column weight latch enable, one cycle after issue
//   o_row_id       row receiving weights
//   o_weight_sel   weight-path mux select
module systolic_wsched_pipe #(
    parameter int PE_COL     = 8,
    parameter int BIT_ROW_ID = 3
) (
    input  logic                  CLK,
    input  logic                  RSTb,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic                  i_sel,
    input  logic [BIT_ROW_ID-1:0] i_row_id,
    input  logic [PE_COL-1:0]     i_mask,
    output logic [PE_COL-1:0]     o_en_w,
    output logic [BIT_ROW_ID-1:0] o_row_id,
    output logic                  o_weight_sel
);

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            o_en_w       <= '0;
            o_row_id     <= '0;
            o_weight_sel <= 1'b0;
        end else if (i_flush || !i_valid) begin
            o_en_w       <= '0;
            o_row_id     <= '0;
            o_weight_sel <= 1'b0;
        end else begin
            o_en_w       <= i_mask;
            o_row_id     <= i_row_id;
            o_weight_sel <= i_sel;
        end
    end

endmodule

// File: rtl/systolic_weight_sched.sv
// rtl/systolic_weight_sched.sv - weight preload sequencer: SRAM row reads steered into the systolic array
//
// Optional feature macro: SYSTOLIC_WSCHED_ZERO_PAD_EN (zero-pad rows n..PE_ROW-1 after the reads)
//
// Ports:
//   CLK, RSTb             clock, asynchronous active-low reset
//   i_start               start request, sampled only when idle
//   i_abort               cancel an in-progress load
//   i_base_addr           SRAM address of row 0
//   i_num_rows            rows to load, clamped to PE_ROW
//   i_col_mask            columns to load
//   o_busy                sequence in progress
//   o_done                one-cycle completion pulse
//   o_sram_weight_en      per-bank read enable
//   o_sram_weight_we      always 0
//   o_sram_weight_addr    per-bank read address (all banks equal)
//   o_systolic_en_w       per-column weight latch enable
//   o_systolic_en_row_id  row receiving weights
//   o_weight_sel          1 = SRAM data to array, 0 = zero weights
module systolic_weight_sched
    import systolic_weight_sched_pkg::*;
#(
    parameter int PE_ROW     = WS_PE_ROW,
    parameter int PE_COL     = WS_PE_COL,
    parameter int BIT_ADDR   = WS_ADDR_W,
    parameter int BIT_ROW_ID = WS_ROW_ID_W
) (
    input  logic                       CLK,
    input  logic                       RSTb,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic [BIT_ADDR-1:0]        i_base_addr,
    input  logic [BIT_ROW_ID:0]        i_num_rows,
    input  logic [PE_COL-1:0]          i_col_mask,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [PE_COL-1:0]          o_sram_weight_en,
    output logic [PE_COL-1:0]          o_sram_weight_we,
    output logic [PE_COL*BIT_ADDR-1:0] o_sram_weight_addr,
    output logic [PE_COL-1:0]          o_systolic_en_w,
    output logic [BIT_ROW_ID-1:0]      o_systolic_en_row_id,
    output logic                       o_weight_sel
);

    localparam logic [BIT_ROW_ID:0]   ROWS_MAX = (BIT_ROW_ID+1)'(PE_ROW);
    localparam logic [BIT_ROW_ID-1:0] ROW_LAST = BIT_ROW_ID'(PE_ROW - 1);

    logic [WS_STATE_W-1:0] state;
    logic [BIT_ROW_ID:0]   n_rows;
    logic [BIT_ROW_ID-1:0] row;
    logic [PE_COL-1:0]     mask_q;
    logic [BIT_ADDR-1:0]   addr_q;
    logic                  iss_valid;
    logic                  iss_sel;
    logic                  active;
    logic                  flush;
    logic                  last_read;
    logic [BIT_ROW_ID:0]   n_start;

    assign n_start   = (i_num_rows > ROWS_MAX) ? ROWS_MAX : i_num_rows;
    assign last_read = ({1'b0, row} == (n_rows - 1'b1));
    assign active    = (state == ST_READ) || (state == ST_DRAIN) || (state == ST_PAD);
    // Abort kills the row whose SRAM data is still in flight, not just future reads
    assign flush     = i_abort && active;

    assign o_sram_weight_we   = '0;
    assign o_sram_weight_addr = {PE_COL{addr_q}};

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state            <= ST_IDLE;
            n_rows           <= '0;
            row              <= '0;
            mask_q           <= '0;
            addr_q           <= '0;
            iss_valid        <= 1'b0;
            iss_sel          <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_sram_weight_en <= '0;
        end else begin
            o_done <= 1'b0;
            if (flush) begin
                state            <= ST_IDLE;
                addr_q           <= '0;
                iss_valid        <= 1'b0;
                iss_sel          <= 1'b0;
                o_busy           <= 1'b0;
                o_sram_weight_en <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_start) begin
                            mask_q <= i_col_mask;
                            n_rows <= n_start;
                            row    <= '0;
                            addr_q <= i_base_addr;
                            if (n_start == '0) begin
                                state  <= ST_DONE;
                                o_done <= 1'b1;
                            end else begin
                                state            <= ST_READ;
                                o_busy           <= 1'b1;
                                o_sram_weight_en <= i_col_mask;
                                iss_valid        <= 1'b1;
                                iss_sel          <= 1'b1;
                            end
                        end
                    end
                    ST_READ: begin
                        if (last_read) begin
                            o_sram_weight_en <= '0;
                            addr_q           <= '0;
`ifdef SYSTOLIC_WSCHED_ZERO_PAD_EN
                            // Pad rows are issued straight after the reads so they
                            // follow the last SRAM row through the same pipe stage
                            if (n_rows < ROWS_MAX) begin
                                state   <= ST_PAD;
                                row     <= n_rows[BIT_ROW_ID-1:0];
                                iss_sel <= 1'b0;
                            end else begin
                                state     <= ST_DRAIN;
                                iss_valid <= 1'b0;
                                iss_sel   <= 1'b0;
                            end
`else
                            state     <= ST_DRAIN;
                            iss_valid <= 1'b0;
                            iss_sel   <= 1'b0;
`endif
                        end else begin
                            row    <= row + 1'b1;
                            addr_q <= addr_q + 1'b1;
                        end
                    end
`ifdef SYSTOLIC_WSCHED_ZERO_PAD_EN
                    ST_PAD: begin
                        if (row == ROW_LAST) begin
                            state     <= ST_DRAIN;
                            iss_valid <= 1'b0;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
`endif
                    ST_DRAIN: begin
                        state  <= ST_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    systolic_wsched_pipe #(
        .PE_COL     (PE_COL),
        .BIT_ROW_ID (BIT_ROW_ID)
    ) u_pipe (
        .CLK          (CLK),
        .RSTb         (RSTb),
        .i_flush      (flush),
        .i_valid      (iss_valid),
        .i_sel        (iss_sel),
        .i_row_id     (row),
        .i_mask       (mask_q),
        .o_en_w       (o_systolic_en_w),
        .o_row_id     (o_systolic_en_row_id),
        .o_weight_sel (o_weight_sel)
    );

endmodule

// File: tb/tb_systolic_weight_sched.sv
// tb/tb_systolic_weight_sched.sv - directed self-checking bench for systolic_weight_sched
module tb_systolic_weight_sched;

    logic         CLK = 1'b0;
    logic         RSTb = 1'b0;
    logic         i_start = 1'b0;
    logic         i_abort = 1'b0;
    logic [14:0]  i_base_addr = '0;
    logic [3:0]   i_num_rows = '0;
    logic [7:0]   i_col_mask = '0;
    logic         o_busy;
    logic         o_done;
    logic [7:0]   o_sram_weight_en;
    logic [7:0]   o_sram_weight_we;
    logic [119:0] o_sram_weight_addr;
    logic [7:0]   o_systolic_en_w;
    logic [2:0]   o_systolic_en_row_id;
    logic         o_weight_sel;

    int checks = 0;
    int errors = 0;

    logic [21:0] obs;
    assign obs = {o_busy, o_done, o_sram_weight_en, o_systolic_en_w, o_systolic_en_row_id, o_weight_sel};

    systolic_weight_sched dut (
        .CLK                  (CLK),
        .RSTb                 (RSTb),
        .i_start              (i_start),
        .i_abort              (i_abort),
        .i_base_addr          (i_base_addr),
        .i_num_rows           (i_num_rows),
        .i_col_mask           (i_col_mask),
        .o_busy               (o_busy),
        .o_done               (o_done),
        .o_sram_weight_en     (o_sram_weight_en),
        .o_sram_weight_we     (o_sram_weight_we),
        .o_sram_weight_addr   (o_sram_weight_addr),
        .o_systolic_en_w      (o_systolic_en_w),
        .o_systolic_en_row_id (o_systolic_en_row_id),
        .o_weight_sel         (o_weight_sel)
    );

    always #5 CLK = ~CLK;

    // Expected {busy, done, sram_en, en_w, row_id, sel} for cycle T+k of a load of n rows
    function automatic logic [21:0] exp_ctl(input int k, input int n, input logic [7:0] m);
        int          last;
        logic        busy, done, act, sel;
        logic [7:0]  se, ew;
        logic [2:0]  rid;
`ifdef SYSTOLIC_WSCHED_ZERO_PAD_EN
        last = (n > 0) ? 8 : 0;
`else
        last = n;
`endif
        busy = (n > 0) && (k >= 1) && (k <= last + 1);
        done = (n == 0) ? (k == 1) : (k == last + 2);
        se   = (k >= 1 && k <= n) ? m : 8'h00;
        act  = (n > 0) && (k >= 2) && (k <= last + 1);
        ew   = act ? m : 8'h00;
        rid  = act ? 3'(k - 2) : 3'd0;
        sel  = act && ((k - 2) < n);
        return {busy, done, se, ew, rid, sel};
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        checks++;
        if (obs !== 22'h0 || o_sram_weight_addr !== '0 || o_sram_weight_we !== 8'h00) begin
            errors++;
            $display("FAIL reset_held ctl=%h addr=%h we=%h required all zero", obs, o_sram_weight_addr, o_sram_weight_we);
        end
        RSTb = 1'b1;
        @(negedge CLK);
        checks++;
        if (obs !== 22'h0 || o_sram_weight_addr !== '0) begin
            errors++;
            $display("FAIL reset_released ctl=%h addr=%h required all zero", obs, o_sram_weight_addr);
        end
    endtask

    task automatic test_full_load();
        logic [14:0] ea;
        @(negedge CLK);
        i_base_addr = 15'd100; i_num_rows = 4'd8; i_col_mask = 8'hFF; i_start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        i_start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge CLK);
            checks++;
            if (obs !== exp_ctl(k, 8, 8'hFF)) begin
                errors++;
                $display("FAIL full_load_ctl k=%0d got %h required %h", k, obs, exp_ctl(k, 8, 8'hFF));
            end
            if (k <= 8) begin
                ea = 15'(100 + k - 1);
                checks++;
                if (o_sram_weight_addr !== {8{ea}} || o_sram_weight_we !== 8'h00) begin
                    errors++;
                    $display("FAIL full_load_addr k=%0d got %h required %h", k, o_sram_weight_addr, {8{ea}});
                end
            end
            // A second start while busy must be ignored
            if (k == 3) begin
                i_start = 1'b1; i_base_addr = 15'd999;
            end else if (k == 4) begin
                i_start = 1'b0; i_base_addr = 15'd100;
            end
        end
    endtask

    task automatic test_addr_wrap();
        logic [14:0] ea;
        @(negedge CLK);
        // Abort together with start in IDLE: start wins
        i_base_addr = 15'd32766; i_num_rows = 4'd4; i_col_mask = 8'hA5; i_start = 1'b1; i_abort = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        i_start = 1'b0; i_abort = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge CLK);
            checks++;
            if (obs !== exp_ctl(k, 4, 8'hA5)) begin
                errors++;
                $display("FAIL wrap_ctl k=%0d got %h required %h", k, obs, exp_ctl(k, 4, 8'hA5));
            end
            if (k <= 4) begin
                ea = 15'(32766 + k - 1);
                checks++;
                if (o_sram_weight_addr !== {8{ea}}) begin
                    errors++;
                    $display("FAIL wrap_addr k=%0d got %h required %h", k, o_sram_weight_addr, {8{ea}});
                end
            end
        end
    endtask

    task automatic test_zero_rows();
        @(negedge CLK);
        i_base_addr = 15'd5; i_num_rows = 4'd0; i_col_mask = 8'hFF; i_start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        i_start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) @(negedge CLK);
            checks++;
            if (obs !== exp_ctl(k, 0, 8'hFF)) begin
                errors++;
                $display("FAIL zero_rows k=%0d got %h required %h", k, obs, exp_ctl(k, 0, 8'hFF));
            end
        end
    endtask

    task automatic test_clamp();
        logic [14:0] ea;
        @(negedge CLK);
        i_base_addr = 15'd7; i_num_rows = 4'd15; i_col_mask = 8'h0F; i_start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        i_start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge CLK);
            checks++;
            if (obs !== exp_ctl(k, 8, 8'h0F)) begin
                errors++;
                $display("FAIL clamp_ctl k=%0d got %h required %h", k, obs, exp_ctl(k, 8, 8'h0F));
            end
            if (k == 8) begin
                ea = 15'd14;
                checks++;
                if (o_sram_weight_addr !== {8{ea}}) begin
                    errors++;
                    $display("FAIL clamp_last_addr got %h required %h", o_sram_weight_addr, {8{ea}});
                end
            end
        end
    endtask

    task automatic test_zero_mask();
        @(negedge CLK);
        i_base_addr = 15'd40; i_num_rows = 4'd3; i_col_mask = 8'h00; i_start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        i_start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge CLK);
            checks++;
            if (obs !== exp_ctl(k, 3, 8'h00)) begin
                errors++;
                $display("FAIL zero_mask k=%0d got %h required %h", k, obs, exp_ctl(k, 3, 8'h00));
            end
        end
    endtask

    task automatic test_abort();
        @(negedge CLK);
        i_base_addr = 15'd200; i_num_rows = 4'd8; i_col_mask = 8'hFF; i_start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        i_start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge CLK);
            checks++;
            if (obs !== exp_ctl(k, 8, 8'hFF)) begin
                errors++;
                $display("FAIL abort_pre k=%0d got %h required %h", k, obs, exp_ctl(k, 8, 8'hFF));
            end
        end
        i_abort = 1'b1;
        @(negedge CLK);
        i_abort = 1'b0;
        checks++;
        if (obs !== 22'h0) begin
            errors++;
            $display("FAIL abort_flush got %h required %h", obs, 22'h0);
        end
        // New start accepted the cycle right after the abort
        i_base_addr = 15'd50; i_num_rows = 4'd1; i_col_mask = 8'h03; i_start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        i_start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge CLK);
            checks++;
            if (obs !== exp_ctl(k, 1, 8'h03)) begin
                errors++;
                $display("FAIL abort_restart k=%0d got %h required %h", k, obs, exp_ctl(k, 1, 8'h03));
            end
            if (k == 1) begin
                checks++;
                if (o_sram_weight_addr !== {8{15'd50}}) begin
                    errors++;
                    $display("FAIL abort_restart_addr got %h required %h", o_sram_weight_addr, {8{15'd50}});
                end
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge CLK);
        i_base_addr = 15'd300; i_num_rows = 4'd8; i_col_mask = 8'h81; i_start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        i_start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) @(negedge CLK);
            checks++;
            if (obs !== exp_ctl(k, 8, 8'h81)) begin
                errors++;
                $display("FAIL rst_pre k=%0d got %h required %h", k, obs, exp_ctl(k, 8, 8'h81));
            end
        end
        #1 RSTb = 1'b0;
        #1;
        checks++;
        if (obs !== 22'h0 || o_sram_weight_addr !== '0) begin
            errors++;
            $display("FAIL rst_async got ctl=%h addr=%h required zero", obs, o_sram_weight_addr);
        end
        @(negedge CLK);
        @(negedge CLK);
        RSTb = 1'b1;
        i_base_addr = 15'd10; i_num_rows = 4'd2; i_col_mask = 8'h01; i_start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        i_start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge CLK);
            checks++;
            if (obs !== exp_ctl(k, 2, 8'h01)) begin
                errors++;
                $display("FAIL rst_fresh k=%0d got %h required %h", k, obs, exp_ctl(k, 2, 8'h01));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_addr_wrap();
        test_zero_rows();
        test_clamp();
        test_zero_mask();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
